// File: rtl/vga_framebuffer_display.sv
// 640x480@60 VGA scan-out of an IMG_W x IMG_H framebuffer placed at a relocatable origin,
// with a custom-instruction command port for pixel write/read, origin and background.
module vga_framebuffer_display #(
  parameter int         IMG_W  = 64,
  parameter int         IMG_H  = 64,
  parameter int         PIX_W  = 1,
  parameter int         X0_DEF = 0,
  parameter int         Y0_DEF = 0,
  parameter logic [2:0] BG_DEF = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic        start,
  output logic        done,
  output logic [31:0] result,
  output logic [2:0]  pixel,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int XW   = $clog2(IMG_W);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RDWAIT, S_DONE} state_t;

  logic             pe_q;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [9:0]       sx_q, sx_d, sy_q, sy_d;
  logic             vis1_q, vis1_d, win1_q, win1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [2:0]       pixel_q, pixel_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic [9:0]       hoff, voff;
  logic             in_x, in_y;
  logic [AW-1:0]    addr_b, addr_a;
  logic [PIX_W-1:0] q_a_q, q_b_q;
  logic [2:0]       colour;

  state_t           state_q, state_d;
  logic [31:0]      cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d;
  logic [31:0]      result_q, result_d;
  logic [9:0]       org_x_q, org_x_d, org_y_q, org_y_d;
  logic [2:0]       bg_q, bg_d;
  logic             addr_valid, wr_en;
  logic             unused_bits;

  logic [PIX_W-1:0] mem [NPIX];

  assign unused_bits = ^{cmd_b_q[31:26], cmd_b_q[15:10], hoff[9:XW]};

  generate
    if (PIX_W == 1) begin : g_mono
      assign colour = {3{q_b_q[0]}};
    end else begin : g_rgb
      assign colour = 3'(q_b_q);
    end
  endgenerate

  // 11-bit sums keep sx+IMG_W from wrapping, so a clipped image never reappears at column 0
  assign in_x   = ({1'b0, h_q} >= {1'b0, sx_q}) && ({1'b0, h_q} < ({1'b0, sx_q} + 11'(IMG_W)));
  assign in_y   = ({1'b0, v_q} >= {1'b0, sy_q}) && ({1'b0, v_q} < ({1'b0, sy_q} + 11'(IMG_H)));
  assign hoff   = h_q - sx_q;
  assign voff   = v_q - sy_q;
  assign addr_b = AW'({voff, hoff[XW-1:0]});

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    vis1_d  = vis1_q;
    win1_d  = win1_q;
    hs1_d   = hs1_q;
    vs1_d   = vs1_q;
    pixel_d = pixel_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pe_q) begin
      if (h_q == 10'd799) begin
        h_d = 10'd0;
        v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      if (h_q == 10'd0 && v_q == 10'd0) begin
        sx_d = org_x_q;
        sy_d = org_y_q;
      end
      vis1_d  = (h_q < 10'd640) && (v_q < 10'd480);
      win1_d  = in_x && in_y;
      hs1_d   = !(h_q >= 10'd656 && h_q <= 10'd751);
      vs1_d   = !(v_q >= 10'd490 && v_q <= 10'd491);
      pixel_d = vis1_q ? (win1_q ? colour : bg_q) : 3'b000;
      hsync_d = hs1_q;
      vsync_d = vs1_q;
    end
  end

  assign addr_a     = cmd_a_q[AW-1:0];
  assign addr_valid = cmd_a_q[29:0] < 30'(NPIX);

  always_comb begin
    state_d  = state_q;
    cmd_a_d  = cmd_a_q;
    cmd_b_d  = cmd_b_q;
    result_d = result_q;
    org_x_d  = org_x_q;
    org_y_d  = org_y_q;
    bg_d     = bg_q;
    wr_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_a_d = dataa;
          cmd_b_d = datab;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        case (cmd_a_q[31:30])
          2'b00: begin
            wr_en    = addr_valid && !reset;
            result_d = addr_valid ? 32'd0 : 32'd1;
          end
          2'b01: begin
            if (addr_valid) state_d = S_RDWAIT;
            else            result_d = 32'd1;
          end
          2'b10: begin
            org_x_d  = cmd_b_q[9:0];
            org_y_d  = cmd_b_q[25:16];
            result_d = 32'd0;
          end
          default: begin
            bg_d     = cmd_b_q[2:0];
            result_d = 32'd0;
          end
        endcase
      end
      S_RDWAIT: begin
        result_d = 32'(q_a_q);
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM has no reset: contents survive a reset by design
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_a] <= cmd_b_q[PIX_W-1:0];
    q_a_q <= mem[addr_a];
    if (pe_q) q_b_q <= mem[addr_b];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pe_q     <= 1'b0;
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      sx_q     <= 10'(X0_DEF);
      sy_q     <= 10'(Y0_DEF);
      vis1_q   <= 1'b0;
      win1_q   <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      pixel_q  <= 3'b000;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      state_q  <= S_IDLE;
      cmd_a_q  <= 32'd0;
      cmd_b_q  <= 32'd0;
      result_q <= 32'd0;
      org_x_q  <= 10'(X0_DEF);
      org_y_q  <= 10'(Y0_DEF);
      bg_q     <= BG_DEF;
    end else begin
      pe_q     <= !pe_q;
      h_q      <= h_d;
      v_q      <= v_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      vis1_q   <= vis1_d;
      win1_q   <= win1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      pixel_q  <= pixel_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      state_q  <= state_d;
      cmd_a_q  <= cmd_a_d;
      cmd_b_q  <= cmd_b_d;
      result_q <= result_d;
      org_x_q  <= org_x_d;
      org_y_q  <= org_y_d;
      bg_q     <= bg_d;
    end
  end

  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign pixel     = pixel_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;

endmodule
